// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// State encoding, end-of-memory marker and the fetch packet bundle.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } state_e;

  localparam logic [31:0] EOF_WORD_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetch packets between the memory response and decode.
// Flush wins over push; push and pop together on a full buffer is allowed.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic [1:0] count,
  output logic       empty
);

  fetch_pkt_t mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
      end
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch initiator: drives imem, tracks the 1-cycle read latency,
// buffers {pc, instr} for decode, handles redirects and EOF halt.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EOF_WORD = EOF_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic        push;
  logic        pop;
  logic        flush;
  logic        buf_empty;
  logic [1:0]  buf_cnt;
  fetch_pkt_t  head;
  fetch_pkt_t  din;
  logic        is_eof;
  logic [2:0]  occ;

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (buf_cnt),
    .empty (buf_empty)
  );

  assign out_valid = !buf_empty && !redirect_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign halted    = (state_q == HALT);
  assign fault     = (state_q == FAULT);
  assign pop       = out_valid && out_ready;
  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
  assign din       = '{pc: rsp_pc_q, instr: imem_instr};
  assign is_eof    = rsp_valid_q && (imem_instr == EOF_WORD);

  // Slots committed after this cycle; issuing is safe while at most one.
  assign occ = {1'b0, buf_cnt} + {2'b0, rsp_valid_q} - {2'b0, pop};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d     = RUN;
        rsp_valid_d = 1'b1;
        rsp_pc_d    = redirect_pc;
        fetch_pc_d  = redirect_pc + 32'd4;
      end else begin
        state_d = FAULT;
      end
    end else begin
      if (rsp_valid_q) begin
        if (is_eof) begin
          state_d = HALT;
        end else begin
          push = 1'b1;
        end
      end
      if (state_q == RUN && !is_eof && occ <= 3'd1) begin
        rsp_valid_d = 1'b1;
        rsp_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a registered-read memory model.
// Directed tests: stream, backpressure, EOF halt, redirects, async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mem [0:63];
  logic [63:0] exp_q [$];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) imem_instr <= rd(imem_addr);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected", {out_pc, out_instr}, 64'hX);
      end else begin
        chk("pkt", {out_pc, out_instr}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic fill4();
    clr_mem();
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    tick();
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_out", {out_pc, out_instr}, 64'd0);
    chk("rst_hf", {62'd0, halted, fault}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string nm);
    repeat (12) tick();
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    // A: free-running stream
    fill4();
    out_ready = 1'b1;
    do_reset();
    ex(32'h0, 32'h11); ex(32'h4, 32'h22);
    ex(32'h8, 32'h33); ex(32'hC, 32'h44);
    chk("a_addr0", 64'(imem_addr), 64'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("a_addr", 64'(imem_addr), 64'(4 * k));
      if (k == 2) chk("a_first", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h0});
    end
    drain("a_drain");
    chk("a_halt", {63'd0, halted}, 64'd1);

    // B: backpressure in cycles 3-5
    fill4();
    out_ready = 1'b1;
    do_reset();
    ex(32'h0, 32'h11); ex(32'h4, 32'h22);
    ex(32'h8, 32'h33); ex(32'hC, 32'h44);
    tick(); tick();
    tick();
    out_ready = 1'b0;
    #1;
    for (int k = 3; k < 6; k++) begin
      chk("b_hold", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h4});
      chk("b_addr", 64'(imem_addr), 64'hC);
      tick();
    end
    out_ready = 1'b1;
    drain("b_drain");

    // C: EOF at 0x08, then resume with a redirect to 0
    clr_mem();
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    out_ready = 1'b1;
    do_reset();
    ex(32'h0, 32'h11); ex(32'h4, 32'h22);
    tick(); tick(); tick();
    chk("c_nohalt", {63'd0, halted}, 64'd0);
    tick();
    chk("c_halt", {63'd0, halted}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("c_pc", 64'(imem_addr), 64'hC);
      tick();
    end
    drain("c_drain");
    mem[2] = 32'h33;
    ex(32'h0, 32'h11); ex(32'h4, 32'h22); ex(32'h8, 32'h33);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    #1;
    chk("c_raddr", 64'(imem_addr), 64'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c_unhalt", {63'd0, halted}, 64'd0);
    drain("c_drain2");

    // D: redirect while the buffer holds two entries
    fill4();
    mem[16] = 32'h400;
    mem[17] = 32'h404;
    out_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("d_full", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h0});
    ex(32'h40, 32'h400); ex(32'h44, 32'h404);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    out_ready = 1'b1;
    #1;
    chk("d_mask", {63'd0, out_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("d_flush", {63'd0, out_valid}, 64'd0);
    drain("d_drain");

    // E: misaligned redirect faults, aligned one recovers
    clr_mem();
    mem[4] = 32'h1010;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("e_fault", {62'd0, fault, out_valid}, {62'd0, 1'b1, 1'b0});
      tick();
    end
    ex(32'h10, 32'h1010);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("e_clear", {63'd0, fault}, 64'd0);
    tick();
    chk("e_out", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h10});
    drain("e_drain");

    // F: asynchronous reset between clock edges
    fill4();
    out_ready = 1'b1;
    do_reset();
    tick(); tick();
    #3;
    chk("f_pre", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("f_ov", {63'd0, out_valid}, 64'd0);
    do_reset();
    ex(32'h0, 32'h11); ex(32'h4, 32'h22);
    ex(32'h8, 32'h33); ex(32'hC, 32'h44);
    chk("f_addr", 64'(imem_addr), 64'h0);
    drain("f_drain");
    #3;
    chk("f_hpre", {63'd0, halted}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("f_halt", {63'd0, halted}, 64'd0);
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    #3;
    chk("f_fpre", {63'd0, fault}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("f_fault", {63'd0, fault}, 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
